axi4_wr_burst_mgr: RTL and testbench
====================================

AXI4_WR_BURST_MGR -- requirements
Module: axi4_wr_burst_mgr

Interface
REQ-001 Parameter AXI4_ADDR_WIDTH, default 32: AXI address width.
REQ-002 Parameter AXI4_DATA_WIDTH, default 64: data width; a power of 2, 32..1024.
REQ-003 Parameter DATA_COUNT_WIDTH, default 16: width of the beat-count request.
REQ-004 Parameter MAX_BURST_LEN, default 256: maximum beats per burst; range 1..256.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock; all logic on the rising edge.
REQ-007 rstn_i  in  1  asynchronous active-low reset.
REQ-008 req_i  in  1  start request; sampled only in IDLE.
REQ-009 addr_i  in  AXI4_ADDR_WIDTH  start byte address; sampled with req_i.
REQ-010 data_count_i  in  DATA_COUNT_WIDTH  total beats; sampled with req_i.
REQ-011 wr_fifo_data_i  in  AXI4_DATA_WIDTH  head of the source FIFO (first-word-fall-through).
REQ-012 wr_fifo_empty_i  in  1  source FIFO empty.
REQ-013 wr_fifo_req_o  out  1  FIFO pop; one pulse per accepted W beat.
REQ-014 busy_o  out  1  a transfer is in progress.
REQ-015 done_o  out  1  one-cycle pulse at transfer completion.
REQ-016 err_o  out  2  latched BRESP error code.
REQ-017 axi_mgr_if  axi4_bus_if.Manager  AXI4 manager port; the AR/R channels are driven inactive (ar_valid=0, r_ready=0).

Function
REQ-018 States SHALL be IDLE, CALC, AW, W and B.
REQ-019 IDLE with req_i=1 and data_count_i!=0 SHALL:
- capture addr_i with its low log2(AXI4_DATA_WIDTH/8) bits forced to 0;
- capture data_count_i as remaining;
- clear err_o, set busy_o and go to CALC.
REQ-020 IDLE with req_i=1 and data_count_i=0 SHALL pulse done_o in the next cycle; no AXI traffic; busy_o stays 0.
REQ-021 req_i SHALL be ignored outside IDLE.
REQ-022 CALC SHALL register the burst length in one cycle: blen = min(remaining, MAX_BURST_LEN, beats to the next 4 KiB boundary).
- beats to boundary = (4096 - addr[11:0]) / (AXI4_DATA_WIDTH/8).
- CALC then goes to AW.
REQ-023 AW SHALL hold the following stable until aw_ready=1, then go to W:
- aw_valid=1, aw_addr=current address, aw_len=blen-1;
- aw_size=log2(AXI4_DATA_WIDTH/8), aw_burst=INCR;
- aw_id, lock, cache, prot, qos, region, atop and user = 0.
REQ-024 W SHALL drive w_valid=!wr_fifo_empty_i, w_data=wr_fifo_data_i and w_strb all ones.
- A beat is accepted when w_valid and w_ready are both 1; only then does wr_fifo_req_o=1.
- w_valid SHALL NOT be asserted before the AW of the same burst is accepted.
REQ-025 w_last SHALL be 1 exactly on the blen-th beat; after that beat is accepted, go to B.
REQ-026 The beat counter SHALL be 9 bits wide.
REQ-027 B SHALL drive b_ready=1. On b_valid:
- address += blen*(AXI4_DATA_WIDTH/8);
- remaining -= blen;
- if remaining=0: go to IDLE, clear busy_o, pulse done_o in the same edge;
- otherwise go to CALC.
REQ-028 A b_resp other than OKAY SHALL load err_o; a later non-OKAY response overwrites it; err_o holds until the next accepted request.
- The transfer SHALL continue after an error.
REQ-029 Address arithmetic SHALL wrap modulo 2^AXI4_ADDR_WIDTH; no burst crosses a 4 KiB boundary.
REQ-030 If the FIFO is empty mid-burst, w_valid SHALL drop with no pop and no beat; beat order SHALL be preserved.
REQ-031 Only one burst SHALL be outstanding at a time; AW, W and B are strictly sequential.

Reset
REQ-032 On rstn_i=0, at any time including mid-burst, all of the following SHALL be 0 and state SHALL be IDLE; no partial transfer resumes after reset:
- busy_o, done_o, err_o, wr_fifo_req_o;
- aw_valid, w_valid, w_last, w_strb, b_ready, aw_addr, aw_len.

Verification
REQ-033 req with addr=0x1000, count=1, 64-bit data -> one AW (addr 0x1000, len 0), one W beat with w_last=1, one pop, done_o pulse, err_o=0.
REQ-034 addr=0x0, count=300, MAX_BURST_LEN=256, 64-bit data -> two bursts:
- first: AW 0x000, len 255;
- second: AW 0x800, len 43;
- 300 pops in total, one done_o.
REQ-035 addr=0xFE0, count=8, 64-bit data -> two bursts:
- first: AW 0xFE0, len 3;
- second: AW 0x1000, len 3.
REQ-036 Random wr_fifo_empty_i and w_ready stalls during a count=16 transfer -> w_valid never set while empty, pops equal accepted beats, data order matches the FIFO order.
REQ-037 count=512 with b_resp=SLVERR on the first burst -> both bursts complete, err_o=2'b10 at done_o; the next req clears err_o to 0.
REQ-038 rstn_i asserted during the W state of a count=64 transfer -> all outputs 0 the next cycle; a following req with count=4 completes normally.

Source files
------------

// File: rtl/axi4_wr_burst_mgr_if.sv
// rtl/axi4_wr_burst_mgr_if.sv - AXI4 bus interface with manager and subordinate views
interface axi4_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [5:0]          aw_atop;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
    logic                r_ready;

    modport Manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Subordinate (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_wr_burst_mgr.sv
// rtl/axi4_wr_burst_mgr.sv - AXI4 write burst manager streaming a FWFT FIFO to memory
module axi4_wr_burst_mgr #(
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_DATA_WIDTH  = 64,
    parameter int DATA_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN    = 256
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        req_i,
    input  logic [AXI4_ADDR_WIDTH-1:0]  addr_i,
    input  logic [DATA_COUNT_WIDTH-1:0] data_count_i,
    input  logic [AXI4_DATA_WIDTH-1:0]  wr_fifo_data_i,
    input  logic                        wr_fifo_empty_i,
    output logic                        wr_fifo_req_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [1:0]                  err_o,
    axi4_bus_if.Manager                 axi_mgr_if
);
    localparam int AW    = AXI4_ADDR_WIDTH;
    localparam int DW    = AXI4_DATA_WIDTH;
    localparam int DCW   = DATA_COUNT_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int CW    = (DCW > 13) ? DCW : 13;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DCW-1:0]  rem_q, rem_d, rem_next;
    logic [8:0]      blen_q, blen_d;
    logic [8:0]      beat_q, beat_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;

    logic [CW-1:0]   to_bnd, rem_ext, blen_max, blen_c;
    logic            last_beat;

    logic            aw_valid_c, w_valid_c, w_last_c, b_ready_c, fifo_req_c;
    logic [AW-1:0]   aw_addr_c;
    logic [7:0]      aw_len_c;
    logic [2:0]      aw_size_c;
    logic [1:0]      aw_burst_c;
    logic [DW-1:0]   w_data_c;
    logic [BYTES-1:0] w_strb_c;

    // Burst length is the tightest of: beats left, burst cap, beats to the 4 KiB page end.
    always_comb begin
        to_bnd   = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> OFFS);
        rem_ext  = CW'(rem_q);
        blen_max = CW'(MAX_BURST_LEN);
        blen_c   = (rem_ext < blen_max) ? rem_ext : blen_max;
        if (to_bnd < blen_c) blen_c = to_bnd;
    end

    assign last_beat = (beat_q == (blen_q - 9'd1));
    assign rem_next  = rem_q - DCW'(blen_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        blen_d  = blen_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (data_count_i != '0) begin
                        addr_d  = addr_i & ~AW'(BYTES - 1);
                        rem_d   = data_count_i;
                        err_d   = 2'b00;
                        state_d = S_CALC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                blen_d  = blen_c[8:0];
                beat_d  = '0;
                state_d = S_AW;
            end
            S_AW: begin
                if (axi_mgr_if.aw_ready) state_d = S_W;
            end
            S_W: begin
                if (!wr_fifo_empty_i && axi_mgr_if.w_ready) begin
                    if (last_beat) state_d = S_B;
                    else           beat_d  = beat_q + 9'd1;
                end
            end
            S_B: begin
                if (axi_mgr_if.b_valid) begin
                    addr_d = addr_q + (AW'(blen_q) << OFFS);
                    rem_d  = rem_next;
                    if (axi_mgr_if.b_resp != 2'b00) err_d = axi_mgr_if.b_resp;
                    if (rem_next == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        aw_valid_c = 1'b0;
        aw_addr_c  = '0;
        aw_len_c   = '0;
        aw_size_c  = '0;
        aw_burst_c = '0;
        w_valid_c  = 1'b0;
        w_data_c   = '0;
        w_strb_c   = '0;
        w_last_c   = 1'b0;
        b_ready_c  = 1'b0;
        fifo_req_c = 1'b0;
        case (state_q)
            S_AW: begin
                aw_valid_c = 1'b1;
                aw_addr_c  = addr_q;
                aw_len_c   = 8'(blen_q - 9'd1);
                aw_size_c  = 3'(OFFS);
                aw_burst_c = 2'b01;
            end
            S_W: begin
                w_valid_c  = !wr_fifo_empty_i;
                w_data_c   = wr_fifo_data_i;
                w_strb_c   = '1;
                w_last_c   = last_beat;
                fifo_req_c = !wr_fifo_empty_i && axi_mgr_if.w_ready;
            end
            S_B:     b_ready_c = 1'b1;
            default: ;
        endcase
    end

    assign wr_fifo_req_o = fifo_req_c;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

    assign axi_mgr_if.aw_id     = '0;
    assign axi_mgr_if.aw_addr   = aw_addr_c;
    assign axi_mgr_if.aw_len    = aw_len_c;
    assign axi_mgr_if.aw_size   = aw_size_c;
    assign axi_mgr_if.aw_burst  = aw_burst_c;
    assign axi_mgr_if.aw_lock   = 1'b0;
    assign axi_mgr_if.aw_cache  = '0;
    assign axi_mgr_if.aw_prot   = '0;
    assign axi_mgr_if.aw_qos    = '0;
    assign axi_mgr_if.aw_region = '0;
    assign axi_mgr_if.aw_atop   = '0;
    assign axi_mgr_if.aw_user   = '0;
    assign axi_mgr_if.aw_valid  = aw_valid_c;
    assign axi_mgr_if.w_data    = w_data_c;
    assign axi_mgr_if.w_strb    = w_strb_c;
    assign axi_mgr_if.w_last    = w_last_c;
    assign axi_mgr_if.w_user    = '0;
    assign axi_mgr_if.w_valid   = w_valid_c;
    assign axi_mgr_if.b_ready   = b_ready_c;
    assign axi_mgr_if.ar_id     = '0;
    assign axi_mgr_if.ar_addr   = '0;
    assign axi_mgr_if.ar_len    = '0;
    assign axi_mgr_if.ar_size   = '0;
    assign axi_mgr_if.ar_burst  = '0;
    assign axi_mgr_if.ar_valid  = 1'b0;
    assign axi_mgr_if.r_ready   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{axi_mgr_if.b_id, axi_mgr_if.ar_ready, axi_mgr_if.r_id,
                         axi_mgr_if.r_data, axi_mgr_if.r_resp, axi_mgr_if.r_last,
                         axi_mgr_if.r_valid, blen_c[CW-1:9]};
endmodule

// File: tb/tb_axi4_wr_burst_mgr.sv
// tb/tb_axi4_wr_burst_mgr.sv - randomized bench for axi4_wr_burst_mgr against a burst-split model
module tb_axi4_wr_burst_mgr;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DCW = 16;
    localparam int MBL = 256;

    logic           clk = 1'b0;
    logic           rstn_i, req_i;
    logic [AW-1:0]  addr_i;
    logic [DCW-1:0] data_count_i;
    logic [DW-1:0]  wr_fifo_data_i;
    logic           wr_fifo_empty_i;
    logic           wr_fifo_req_o, busy_o, done_o;
    logic [1:0]     err_o;

    always #5 clk = ~clk;

    axi4_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi4_wr_burst_mgr #(
        .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW),
        .DATA_COUNT_WIDTH(DCW), .MAX_BURST_LEN(MBL)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .addr_i(addr_i),
        .data_count_i(data_count_i), .wr_fifo_data_i(wr_fifo_data_i),
        .wr_fifo_empty_i(wr_fifo_empty_i), .wr_fifo_req_o(wr_fifo_req_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .axi_mgr_if(bus)
    );

    int n_cmp = 0, n_bad = 0;
    bit stall = 1'b0;
    int rd_idx = 0, bcnt = 0, b_pend = 0;
    logic [1:0] resp_q[$];
    logic [AW-1:0] obs_aw_addr[$];
    logic [7:0]    obs_aw_len[$];
    logic [DW-1:0] obs_wd[$];
    bit            obs_wl[$];
    int n_pop = 0, n_done = 0, viol = 0, aw_acc = 0, wl_acc = 0, b_acc = 0;
    bit pop, awh, wh, bh, wlh, aw_pv;
    logic [AW-1:0] aw_pa;
    logic [7:0]    aw_pl;

    function automatic logic [DW-1:0] fdata(input int idx);
        logic [31:0] i;
        i = idx;
        return {i ^ 32'hA5A5_0000, i * 32'h9E37_79B9};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_aw_addr.delete(); obs_aw_len.delete(); obs_wd.delete(); obs_wl.delete();
        n_pop = 0; n_done = 0; viol = 0; aw_acc = 0; wl_acc = 0; b_acc = 0;
        bcnt = 0; b_pend = 0;
    endtask

    // Subordinate + FIFO responder and protocol monitor: sample at negedge, drive after posedge.
    initial begin
        aw_pv = 1'b0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
        bus.b_id = '0; bus.ar_ready = 1'b0; bus.r_id = '0; bus.r_data = '0;
        bus.r_resp = 2'b00; bus.r_last = 1'b0; bus.r_valid = 1'b0;
        wr_fifo_empty_i = 1'b0;
        wr_fifo_data_i  = fdata(0);
        forever begin
            @(negedge clk);
            awh = bus.aw_valid && bus.aw_ready;
            wh  = bus.w_valid && bus.w_ready;
            bh  = bus.b_valid && bus.b_ready;
            wlh = wh && bus.w_last;
            pop = wr_fifo_req_o;
            if (bus.w_valid && wr_fifo_empty_i) viol++;
            if (wr_fifo_req_o !== wh) viol++;
            if (bus.w_valid && aw_acc == wl_acc) viol++;
            if (bus.aw_valid && aw_acc != b_acc) viol++;
            if (aw_pv && !(bus.aw_valid && bus.aw_addr == aw_pa && bus.aw_len == aw_pl)) viol++;
            if (bus.ar_valid || bus.r_ready) viol++;
            aw_pv = bus.aw_valid && !bus.aw_ready;
            aw_pa = bus.aw_addr;
            aw_pl = bus.aw_len;
            if (awh) begin obs_aw_addr.push_back(bus.aw_addr); obs_aw_len.push_back(bus.aw_len); aw_acc++; end
            if (wh) begin obs_wd.push_back(bus.w_data); obs_wl.push_back(bus.w_last); end
            if (wlh) wl_acc++;
            if (bh) b_acc++;
            if (done_o) n_done++;
            @(posedge clk);
            #1;
            if (!rstn_i) begin
                bus.b_valid = 1'b0; b_pend = 0; aw_pv = 1'b0;
            end else begin
                if (pop) begin rd_idx++; n_pop++; end
                if (bh) begin bus.b_valid = 1'b0; bcnt++; end
                if (wlh) b_pend++;
                if (!bus.b_valid && b_pend > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
                    bus.b_valid = 1'b1;
                    bus.b_resp  = (bcnt < resp_q.size()) ? resp_q[bcnt] : 2'b00;
                    b_pend--;
                end
            end
            bus.aw_ready    = !stall || ($urandom_range(0, 2) != 0);
            bus.w_ready     = !stall || ($urandom_range(0, 2) != 0);
            wr_fifo_empty_i = stall && ($urandom_range(0, 3) == 0);
            wr_fifo_data_i  = fdata(rd_idx);
        end
    end

    task automatic run_xfer(input logic [AW-1:0] a0, input int cnt, input bit st, input string tag);
        logic [AW-1:0] ea[$];
        int            el[$];
        bit            exp_wl[$];
        logic [AW-1:0] a;
        logic [1:0]    eerr, err_seen;
        int rem, b, bnd, dbad, lbad, start_idx, nb;
        bit got;
        // Reference: split into bursts limited by count, cap and 4 KiB page end.
        a = a0 & ~AW'(DW / 8 - 1);
        rem = cnt;
        while (rem > 0) begin
            b = (rem > MBL) ? MBL : rem;
            bnd = (4096 - int'(a[11:0])) / (DW / 8);
            if (bnd < b) b = bnd;
            ea.push_back(a);
            el.push_back(b - 1);
            for (int k = 0; k < b; k++) exp_wl.push_back(k == b - 1);
            a = a + AW'(b * (DW / 8));
            rem -= b;
        end
        eerr = 2'b00;
        for (int i = 0; i < ea.size() && i < resp_q.size(); i++)
            if (resp_q[i] != 2'b00) eerr = resp_q[i];

        @(negedge clk);
        #1;
        clear_obs();
        stall = st;
        start_idx = rd_idx;
        addr_i = a0;
        data_count_i = DCW'(cnt);
        req_i = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_start"}, busy_o, 1);
        chk({tag, "_err_cleared"}, err_o, 0);
        got = 1'b0;
        err_seen = 2'bxx;
        for (int c = 0; c < 20000 && !got; c++) begin
            #1;
            req_i = $urandom_range(0, 1);
            addr_i = $urandom;
            data_count_i = DCW'($urandom);
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                err_seen = err_o;
                #1 req_i = 1'b0;
                chk({tag, "_busy_at_done"}, busy_o, 0);
            end
        end
        req_i = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        nb = (obs_aw_addr.size() < ea.size()) ? obs_aw_addr.size() : ea.size();
        chk({tag, "_n_aw"}, obs_aw_addr.size(), ea.size());
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s_aw_addr%0d", tag, i), obs_aw_addr[i], ea[i]);
            chk($sformatf("%s_aw_len%0d", tag, i), obs_aw_len[i], el[i]);
        end
        chk({tag, "_n_beats"}, obs_wd.size(), exp_wl.size());
        chk({tag, "_n_pops"}, n_pop, cnt);
        dbad = 0;
        lbad = 0;
        for (int i = 0; i < obs_wd.size(); i++) begin
            if (obs_wd[i] !== fdata(start_idx + i)) dbad++;
            if (i < exp_wl.size() && obs_wl[i] != exp_wl[i]) lbad++;
        end
        chk({tag, "_data_order_errs"}, dbad, 0);
        chk({tag, "_wlast_errs"}, lbad, 0);
        chk({tag, "_protocol_viol"}, viol, 0);
        chk({tag, "_n_done"}, n_done, 1);
        chk({tag, "_err_at_done"}, err_seen, eerr);
        chk({tag, "_err_held"}, err_o, eerr);
    endtask

    initial begin
        int cyc;
        rstn_i = 1'b1;
        req_i = 1'b0;
        addr_i = '0;
        data_count_i = '0;
        #2 rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy_o, done_o, err_o, wr_fifo_req_o, bus.aw_valid, bus.w_valid,
                         bus.w_last, bus.b_ready}, 0);
        chk("rst_aw", {bus.aw_addr, bus.aw_len, bus.w_strb}, 0);
        #1 rstn_i = 1'b1;

        resp_q = {};
        run_xfer(32'h0000_1000, 1, 1'b0, "single");
        run_xfer(32'h0000_0000, 300, 1'b0, "cap256");
        run_xfer(32'h0000_0FE0, 8, 1'b0, "page4k");
        run_xfer($urandom, 16, 1'b1, "stall16");

        // zero-count request: done next cycle, no traffic, never busy
        @(negedge clk);
        #1;
        clear_obs();
        data_count_i = '0;
        addr_i = 32'h0000_4000;
        req_i = 1'b1;
        @(negedge clk);
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        #1 req_i = 1'b0;
        @(negedge clk);
        chk("zero_done_drop", done_o, 0);
        repeat (4) @(negedge clk);
        chk("zero_no_aw", obs_aw_addr.size(), 0);
        chk("zero_n_done", n_done, 1);

        resp_q = {2'b10};
        run_xfer(32'h0000_0000, 512, 1'b0, "slverr");
        resp_q = {};
        run_xfer(32'h0001_0008, 3, 1'b0, "after_err");

        // reset in the middle of the W phase
        @(negedge clk);
        #1;
        clear_obs();
        addr_i = 32'h0000_2000;
        data_count_i = 16'd64;
        req_i = 1'b1;
        @(negedge clk);
        #1 req_i = 1'b0;
        cyc = 0;
        while (obs_wd.size() < 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reach_w", obs_wd.size() >= 5, 1);
        #1 rstn_i = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {busy_o, done_o, err_o, wr_fifo_req_o, bus.aw_valid, bus.w_valid,
                            bus.w_last, bus.b_ready}, 0);
        chk("midrst_aw", {bus.aw_addr, bus.aw_len, bus.w_strb}, 0);
        #1 rstn_i = 1'b1;
        run_xfer(32'h0000_3000, 4, 1'b0, "post_rst");

        for (int t = 0; t < 8; t++) begin
            resp_q = {};
            for (int i = 0; i < 8; i++)
                resp_q.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            run_xfer($urandom, $urandom_range(1, 700), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
